// File: rtl/fetch.sv
// Instruction fetch stage: fetches 32-bit instructions as two 16-bit pipelined
// Wishbone beats and presents them to decode; redirects drain in-flight beats.
module fetch #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        redirect_i,
   input  logic [63:0] redirect_pc_i,
   input  logic        stall_i,
   output logic [31:0] inst_o,
   output logic        inst_en_o,
   output logic [63:0] pc_o,
   output logic [63:0] ibadr_o,
   output logic        ibcyc_o,
   output logic        ibstb_o,
   output logic [1:0]  ibsel_o,
   input  logic        ibstall_i,
   input  logic        iback_i,
   input  logic [15:0] ibdat_i
);

   typedef enum logic [2:0] {
      ISSUE_LO,
      ISSUE_HI,
      WAIT,
      PRESENT,
      DRAIN
   } state_e;

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] pc_out_q, pc_out_d;
   logic [31:0] inst_q, inst_d;
   logic        inst_en_q, inst_en_d;
   logic [15:0] lo_q, lo_d;
   logic        lo_valid_q, lo_valid_d;
   logic [1:0]  out_q, out_d;
   logic [1:0]  discard_q, discard_d;
   logic        issuing, accept, ack_v;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pc_out_d   = pc_out_q;
      inst_d     = inst_q;
      inst_en_d  = inst_en_q;
      lo_d       = lo_q;
      lo_valid_d = lo_valid_q;
      out_d      = out_q;
      discard_d  = discard_q;

      // Strobe is gated by reset so nothing is issued while reset is held.
      issuing = ((state_q == ISSUE_LO) || (state_q == ISSUE_HI)) && !reset_i;
      accept  = issuing && !ibstall_i;
      ack_v   = iback_i && (out_q != 2'd0);

      ibstb_o = issuing;
      ibsel_o = issuing ? 2'b11 : 2'b00;
      ibcyc_o = issuing || (out_q != 2'd0);
      if (!issuing)
         ibadr_o = '0;
      else if (state_q == ISSUE_HI)
         ibadr_o = pc_q + 64'd2;
      else
         ibadr_o = pc_q;

      case ({accept, ack_v})
         2'b10:   out_d = out_q + 2'd1;
         2'b01:   out_d = out_q - 2'd1;
         default: out_d = out_q;
      endcase

      case (state_q)
         ISSUE_LO: if (accept) state_d = ISSUE_HI;
         ISSUE_HI: if (accept) state_d = WAIT;
         PRESENT: begin
            if (!stall_i) begin
               inst_en_d = 1'b0;
               pc_d      = pc_q + 64'd4;
               state_d   = ISSUE_LO;
            end
         end
         DRAIN: begin
            if (discard_q == 2'd0) begin
               state_d = ISSUE_LO;
            end else if (ack_v) begin
               discard_d = discard_q - 2'd1;
               if (discard_q == 2'd1) state_d = ISSUE_LO;
            end
         end
         default: ;
      endcase

      // Acks outside DRAIN belong to the current fetch, in issue order.
      if (state_q != DRAIN && ack_v && !redirect_i) begin
         if (!lo_valid_q) begin
            lo_d       = ibdat_i;
            lo_valid_d = 1'b1;
         end else begin
            lo_valid_d = 1'b0;
            inst_d     = {ibdat_i, lo_q};
            pc_out_d   = pc_q;
            inst_en_d  = 1'b1;
            state_d    = PRESENT;
         end
      end

      if (redirect_i) begin
         pc_d       = {redirect_pc_i[63:2], 2'b00};
         inst_en_d  = 1'b0;
         lo_valid_d = 1'b0;
         if (state_q != DRAIN) begin
            discard_d = out_d;
            state_d   = (out_d == 2'd0) ? ISSUE_LO : DRAIN;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ISSUE_LO;
         pc_q       <= {RESET_PC[63:2], 2'b00};
         pc_out_q   <= '0;
         inst_q     <= '0;
         inst_en_q  <= 1'b0;
         lo_q       <= '0;
         lo_valid_q <= 1'b0;
         out_q      <= '0;
         discard_q  <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pc_out_q   <= pc_out_d;
         inst_q     <= inst_d;
         inst_en_q  <= inst_en_d;
         lo_q       <= lo_d;
         lo_valid_q <= lo_valid_d;
         out_q      <= out_d;
         discard_q  <= discard_d;
      end
   end

   assign inst_o    = inst_q;
   assign inst_en_o = inst_en_q;
   assign pc_o      = pc_out_q;

endmodule
